// File: rtl/objects_draw_pkg.sv
// ============================================================================
// Module : objects_draw_pkg
// Brief  : Shared types and constants for the object draw arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package objects_draw_pkg;

  localparam int DEF_NUM_LAYERS = 4;
  localparam int BG_INDEX       = DEF_NUM_LAYERS;

  typedef logic [7:0] rgb332_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    RUN        = 2'd1,
    REPORT     = 2'd2
  } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/objects_draw_arbiter_priority_encoder.sv
// ============================================================================
// Module : priority_encoder_n
// Brief  : Lowest-index-wins encoder; index = N when nothing is requesting.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module priority_encoder_n
  import objects_draw_pkg::*;
#(
  parameter int N     = DEF_NUM_LAYERS,
  parameter int IDX_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_index
);

  // Walk from the top so the lowest set index is the last one written.
  always_comb begin
    o_found = 1'b0;
    o_index = IDX_W'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found = 1'b1;
        o_index = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/objects_draw_arbiter.sv
// ============================================================================
// Module : objects_draw_arbiter
// Brief  : Per-pixel sprite/background arbiter with per-frame collision report.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module objects_draw_arbiter
  import objects_draw_pkg::*;
#(
  parameter int                    NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int                    RGB_W      = 8,
  parameter logic [NUM_LAYERS-1:0] DEFAULT_EN = '1,
  localparam int                   c_ACT_W    = $clog2(NUM_LAYERS + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layerEnable,
  input  logic [NUM_LAYERS-1:0]       layerDrawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic [RGB_W-1:0]            bgRGB,
  input  logic                        boardersDrawReq,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [c_ACT_W-1:0]          activeLayer,
  output logic [NUM_LAYERS-1:0]       collisionMask,
  output logic                        collisionPulse
);

  frame_state_t          r_state;
  logic [NUM_LAYERS-1:0] r_en_shadow;
  logic [NUM_LAYERS-1:0] r_acc;

  logic [NUM_LAYERS-1:0] w_eff;
  logic                  w_found;
  logic [c_ACT_W-1:0]    w_index;
  logic [RGB_W-1:0]      w_win_rgb;
  logic                  w_multi;
  logic [NUM_LAYERS-1:0] w_hits;

  assign w_eff = layerDrawReq & r_en_shadow;

  priority_encoder_n #(
    .N     (NUM_LAYERS),
    .IDX_W (c_ACT_W)
  ) u_prio (
    .i_req   (w_eff),
    .o_found (w_found),
    .o_index (w_index)
  );

  always_comb begin
    w_win_rgb = bgRGB;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (w_found && (w_index == c_ACT_W'(i))) begin
        w_win_rgb = layerRGB[i*RGB_W +: RGB_W];
      end
    end
  end

  // Two or more effective requesters: a bit already seen meets another one.
  always_comb begin
    logic seen;
    seen    = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_multi = w_multi | (seen & w_eff[i]);
      seen    = seen | w_eff[i];
    end
  end

  assign w_hits = (w_multi || boardersDrawReq) ? w_eff : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      RGBOut         <= '0;
      activeLayer    <= c_ACT_W'(NUM_LAYERS);
      collisionMask  <= '0;
      collisionPulse <= 1'b0;
      r_en_shadow    <= DEFAULT_EN;
      r_acc          <= '0;
      r_state        <= WAIT_FRAME;
    end else begin
      RGBOut         <= w_win_rgb;
      activeLayer    <= w_index;
      collisionPulse <= 1'b0;
      if (startOfFrame) begin
        r_en_shadow <= layerEnable;
      end
      case (r_state)
        WAIT_FRAME: begin
          if (startOfFrame) begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (startOfFrame) begin
            collisionMask  <= r_acc | w_hits;
            collisionPulse <= |(r_acc | w_hits);
            r_acc          <= '0;
            r_state        <= REPORT;
          end else begin
            r_acc <= r_acc | w_hits;
          end
        end
        REPORT: begin
          // A frame edge here closes a one-pixel frame made of this cycle only.
          if (startOfFrame) begin
            collisionMask  <= w_hits;
            collisionPulse <= |w_hits;
            r_acc          <= '0;
          end else begin
            r_acc   <= w_hits;
            r_state <= RUN;
          end
        end
        default: r_state <= WAIT_FRAME;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_objects_draw_arbiter.sv
// ============================================================================
// Module : tb_objects_draw_arbiter
// Brief  : Scoreboard bench for objects_draw_arbiter pixel path and collisions.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_objects_draw_arbiter;
  import objects_draw_pkg::*;

  localparam int c_N  = 4;
  localparam int c_W  = 8;
  localparam int c_AW = 3;

  logic                 clk             = 1'b0;
  logic                 reset           = 1'b1;
  logic                 startOfFrame    = 1'b0;
  logic                 boardersDrawReq = 1'b0;
  logic [c_N-1:0]       layerEnable     = '1;
  logic [c_N-1:0]       layerDrawReq    = '0;
  logic [c_N*c_W-1:0]   layerRGB        = {8'h5A, 8'h03, 8'hE0, 8'h1F};
  rgb332_t              bgRGB           = 8'h1C;
  logic [c_W-1:0]       RGBOut;
  logic [c_AW-1:0]      activeLayer;
  logic [c_N-1:0]       collisionMask;
  logic                 collisionPulse;

  int n_vec = 0;
  int n_err = 0;
  logic [c_N-1:0]        tb_en = '1;
  logic [c_W+c_AW-1:0]   sb_q[$];

  always #5 clk = ~clk;

  objects_draw_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .startOfFrame    (startOfFrame),
    .layerEnable     (layerEnable),
    .layerDrawReq    (layerDrawReq),
    .layerRGB        (layerRGB),
    .bgRGB           (bgRGB),
    .boardersDrawReq (boardersDrawReq),
    .RGBOut          (RGBOut),
    .activeLayer     (activeLayer),
    .collisionMask   (collisionMask),
    .collisionPulse  (collisionPulse)
  );

  function automatic logic [c_W+c_AW-1:0] ref_pixel(input logic [c_N-1:0] req, input logic [c_N-1:0] en);
    logic [c_N-1:0]      eff;
    logic [c_W+c_AW-1:0] res;
    logic                got;
    eff = req & en;
    res = {bgRGB, c_AW'(BG_INDEX)};
    got = 1'b0;
    for (int i = 0; i < c_N; i++) begin
      if (eff[i] && !got) begin
        res = {layerRGB[i*c_W +: c_W], c_AW'(i)};
        got = 1'b1;
      end
    end
    return res;
  endfunction

  // Drive one pixel at a falling edge; returns after the rising edge consumed it.
  task automatic apply(input logic [c_N-1:0] req, input logic brd, input logic sof);
    layerDrawReq    = req;
    boardersDrawReq = brd;
    startOfFrame    = sof;
    sb_q.push_back(ref_pixel(req, tb_en));
    if (sof) tb_en = layerEnable;
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    logic [c_W+c_AW-1:0] exp_px;
    if (sb_q.size() != 0) begin
      #1;
      exp_px = sb_q.pop_front();
      n_vec++;
      if ({RGBOut, activeLayer} !== exp_px) begin
        n_err++;
        $display("FAIL pixel: got RGBOut=%h activeLayer=%0d, want RGBOut=%h activeLayer=%0d",
                 RGBOut, activeLayer, exp_px[c_AW +: c_W], exp_px[c_AW-1:0]);
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if ({RGBOut, activeLayer, collisionMask, collisionPulse} !== {8'h00, 3'd4, 4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: got %h/%0d/%b/%b, want 00/4/0000/0", RGBOut, activeLayer, collisionMask, collisionPulse);
    end
    reset = 1'b0;
    tb_en = '1;
    apply(4'b0000, 1'b0, 1'b0);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL idle_after_reset: got mask=%b pulse=%b, want 0000/0", collisionMask, collisionPulse);
    end
    apply(4'b0110, 1'b0, 1'b0);
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL wait_no_report: got mask=%b pulse=%b, want 0000/0", collisionMask, collisionPulse);
    end
  endtask

  task automatic test_priority();
    apply(4'b0001, 1'b0, 1'b0);
    apply(4'b0100, 1'b0, 1'b0);
    apply(4'b1000, 1'b0, 1'b0);
    apply(4'b0110, 1'b0, 1'b0);
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0110, 1'b1}) begin
      n_err++;
      $display("FAIL layer_collision_report: got mask=%b pulse=%b, want 0110/1", collisionMask, collisionPulse);
    end
    apply(4'b0000, 1'b0, 1'b0);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0110, 1'b0}) begin
      n_err++;
      $display("FAIL pulse_single_cycle: got mask=%b pulse=%b, want 0110/0", collisionMask, collisionPulse);
    end
  endtask

  task automatic test_border();
    apply(4'b0000, 1'b1, 1'b0);
    apply(4'b0010, 1'b0, 1'b0);
    apply(4'b1000, 1'b1, 1'b0);
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b1000, 1'b1}) begin
      n_err++;
      $display("FAIL border_report: got mask=%b pulse=%b, want 1000/1", collisionMask, collisionPulse);
    end
    apply(4'b0001, 1'b0, 1'b0);
    apply(4'b0000, 1'b1, 1'b0);
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL clean_frame: got mask=%b pulse=%b, want 0000/0", collisionMask, collisionPulse);
    end
  endtask

  task automatic test_enable_change();
    apply(4'b0000, 1'b0, 1'b0);
    layerEnable = 4'b1110;
    apply(4'b0001, 1'b0, 1'b0);
    apply(4'b0011, 1'b0, 1'b0);
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0011, 1'b1}) begin
      n_err++;
      $display("FAIL old_enable_frame: got mask=%b pulse=%b, want 0011/1", collisionMask, collisionPulse);
    end
    apply(4'b0001, 1'b0, 1'b0);
    apply(4'b0011, 1'b0, 1'b0);
    apply(4'b0001, 1'b1, 1'b0);
    layerEnable = 4'b1111;
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL disabled_no_collision: got mask=%b pulse=%b, want 0000/0", collisionMask, collisionPulse);
    end
  endtask

  task automatic test_sof_collision();
    apply(4'b0000, 1'b0, 1'b0);
    apply(4'b0000, 1'b0, 1'b0);
    apply(4'b0101, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0101, 1'b1}) begin
      n_err++;
      $display("FAIL sof_cycle_hit: got mask=%b pulse=%b, want 0101/1", collisionMask, collisionPulse);
    end
    apply(4'b0000, 1'b0, 1'b0);
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL next_frame_clear: got mask=%b pulse=%b, want 0000/0", collisionMask, collisionPulse);
    end
  endtask

  task automatic test_back_to_back();
    apply(4'b0000, 1'b0, 1'b0);
    apply(4'b1100, 1'b0, 1'b0);
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b1100, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_first: got mask=%b pulse=%b, want 1100/1", collisionMask, collisionPulse);
    end
    apply(4'b0011, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0011, 1'b1}) begin
      n_err++;
      $display("FAIL b2b_second: got mask=%b pulse=%b, want 0011/1", collisionMask, collisionPulse);
    end
    apply(4'b0000, 1'b0, 1'b0);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0011, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_mask_hold: got mask=%b pulse=%b, want 0011/0", collisionMask, collisionPulse);
    end
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_clean: got mask=%b pulse=%b, want 0000/0", collisionMask, collisionPulse);
    end
  endtask

  task automatic test_reset_midframe();
    apply(4'b0000, 1'b0, 1'b0);
    apply(4'b0110, 1'b0, 1'b0);
    layerDrawReq = '0;
    startOfFrame = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({RGBOut, activeLayer, collisionMask, collisionPulse} !== {8'h00, 3'd4, 4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got %h/%0d/%b/%b, want 00/4/0000/0", RGBOut, activeLayer, collisionMask, collisionPulse);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tb_en = '1;
    apply(4'b0110, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_no_report: got mask=%b pulse=%b, want 0000/0", collisionMask, collisionPulse);
    end
    apply(4'b0000, 1'b0, 1'b0);
    apply(4'b0000, 1'b0, 1'b1);
    n_vec++;
    if ({collisionMask, collisionPulse} !== {4'b0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_cleared_acc: got mask=%b pulse=%b, want 0000/0", collisionMask, collisionPulse);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_priority();
    test_border();
    test_enable_change();
    test_sof_collision();
    test_back_to_back();
    test_reset_midframe();
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
